// File: rtl/fetch_ctrl.sv
// IF-stage sequencing controller: owns the fetch PC, picks the next PC by priority,
// and drives pc_en / flush / if_valid. Optional perf counters under FETCH_CTRL_PERF_EN.
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        ex_redirect_en,
    input  logic [31:0] ex_redirect_pc,
    input  logic        jump_en,
    input  logic [31:0] pc_jump_addr,
    input  logic        btb_pc_valid,
    input  logic        btb_pc_predictTaken,
    input  logic [31:0] btb_target_pc,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        flush,
    output logic        if_valid
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] perf_redirect_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] sel_pc;

    // A redirect from EX outranks a jump presented in the same cycle.
    assign redirect = ex_redirect_en || jump_en;
    assign target   = ex_redirect_en ? ex_redirect_pc : pc_jump_addr;

    always_comb begin
        sel_pc = pc + 32'd4;
        if (state == S_BOOT)
            sel_pc = pc;
        else if (redirect)
            sel_pc = target;
        else if (stall_req)
            sel_pc = pc;
        else if (btb_pc_valid && btb_pc_predictTaken)
            sel_pc = btb_target_pc;
    end

    assign next_pc  = sel_pc & ~32'h3;
    assign pc_en    = (state != S_BOOT) && (redirect || !stall_req);
    assign flush    = (state == S_BOOT) || (state == S_FLUSH);
    assign if_valid = (state == S_RUN) || (state == S_STALL);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN, S_STALL: begin
                if (redirect) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (stall_req) begin
                    state_nxt = S_STALL;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (redirect) begin
                    cnt_nxt = FLUSH_LOAD;
                end else begin
                    // Counts down through stalled cycles too.
                    cnt_nxt = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        cnt_nxt   = 3'd0;
                        state_nxt = stall_req ? S_STALL : S_RUN;
                    end
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_BOOT;
            cnt   <= 3'd0;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pc_en)
                pc <= next_pc;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic redirect_evt, stall_evt;

    assign redirect_evt = (state != S_BOOT) && redirect;
    assign stall_evt    = stall_req && ((state == S_RUN) || (state == S_STALL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_redirect_cnt <= 16'd0;
            perf_stall_cnt    <= 16'd0;
        end else begin
            if (redirect_evt && (perf_redirect_cnt != 16'hFFFF))
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
            if (stall_evt && (perf_stall_cnt != 16'hFFFF))
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, reset/perf sequences, then random
// stimulus against a cycle-level reference model of the fetch rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          FC = 2;

    logic        clk, rst;
    logic        stall_req, ex_redirect_en, jump_en, btb_pc_valid, btb_pc_predictTaken;
    logic [31:0] ex_redirect_pc, pc_jump_addr, btb_target_pc;
    logic [31:0] pc, next_pc;
    logic        pc_en, flush, if_valid;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_redirect_cnt, perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.RESET_VECTOR(RV), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req),
        .ex_redirect_en(ex_redirect_en), .ex_redirect_pc(ex_redirect_pc),
        .jump_en(jump_en), .pc_jump_addr(pc_jump_addr),
        .btb_pc_valid(btb_pc_valid), .btb_pc_predictTaken(btb_pc_predictTaken),
        .btb_target_pc(btb_target_pc),
        .pc(pc), .next_pc(next_pc), .pc_en(pc_en), .flush(flush), .if_valid(if_valid)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_redirect_cnt(perf_redirect_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, rd;
        logic [31:0] rpc;
        logic        jp;
        logic [31:0] jpc;
        logic        bv, bt;
        logic [31:0] bpc;
        logic [31:0] e_pc, e_nxt;
        logic        e_en, e_fl, e_v;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic jp, input logic [31:0] jpc,
                                input logic bv, input logic bt, input logic [31:0] bpc,
                                input logic [31:0] e_pc, input logic [31:0] e_nxt,
                                input logic e_en, input logic e_fl, input logic e_v);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.jp = jp; r.jpc = jpc;
        r.bv = bv; r.bt = bt; r.bpc = bpc;
        r.e_pc = e_pc; r.e_nxt = e_nxt; r.e_en = e_en; r.e_fl = e_fl; r.e_v = e_v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic jp, input logic [31:0] jpc,
                         input logic bv, input logic bt, input logic [31:0] bpc);
        stall_req = st; ex_redirect_en = rd; ex_redirect_pc = rpc;
        jump_en = jp; pc_jump_addr = jpc;
        btb_pc_valid = bv; btb_pc_predictTaken = bt; btb_target_pc = bpc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Reference model state: boot cycle pending, current PC, flush cycles left.
    logic        m_boot;
    logic [31:0] m_pc;
    int          m_fl;

    task automatic model_check(input string tag);
        logic [31:0] tgt;
        logic        en, fl;
        if (!rst) begin
            m_boot = 1'b1; m_pc = RV; m_fl = 0;
            chk({tag, "_rst_pc"}, pc, RV);
            chk({tag, "_rst_flush"}, {31'd0, flush}, 32'd1);
            chk({tag, "_rst_valid"}, {31'd0, if_valid}, 32'd0);
            chk({tag, "_rst_en"}, {31'd0, pc_en}, 32'd0);
        end else if (m_boot) begin
            chk({tag, "_boot_pc"}, pc, m_pc);
            chk({tag, "_boot_next"}, next_pc, m_pc);
            chk({tag, "_boot_flush"}, {31'd0, flush}, 32'd1);
            chk({tag, "_boot_valid"}, {31'd0, if_valid}, 32'd0);
            chk({tag, "_boot_en"}, {31'd0, pc_en}, 32'd0);
            m_boot = 1'b0;
        end else begin
            if (ex_redirect_en)                           tgt = ex_redirect_pc;
            else if (jump_en)                             tgt = pc_jump_addr;
            else if (stall_req)                           tgt = m_pc;
            else if (btb_pc_valid && btb_pc_predictTaken) tgt = btb_target_pc;
            else                                          tgt = m_pc + 32'd4;
            tgt = {tgt[31:2], 2'b00};
            en  = ex_redirect_en || jump_en || !stall_req;
            fl  = (m_fl > 0);
            chk({tag, "_pc"}, pc, m_pc);
            chk({tag, "_next"}, next_pc, tgt);
            chk({tag, "_en"}, {31'd0, pc_en}, {31'd0, en});
            chk({tag, "_flush"}, {31'd0, flush}, {31'd0, fl});
            chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, !fl});
            if (en) m_pc = tgt;
            if (ex_redirect_en || jump_en) m_fl = FC;
            else if (m_fl > 0)             m_fl = m_fl - 1;
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();

        //          st rd rpc           jp jpc          bv bt bpc          pc            next          en fl v
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h0,        32'h0,        0,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h0,        32'h4,        1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h4,        32'h8,        1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h8,        32'hC,        1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'hC,        32'h10,       1,0,1));
        tbl.push_back(mk(0,1,32'h200,      0,32'h0,   0,0,32'h0,   32'h10,       32'h200,      1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h200,      32'h204,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h204,      32'h208,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h208,      32'h20C,      1,0,1));
        tbl.push_back(mk(0,1,32'h300,      1,32'h400, 0,0,32'h0,   32'h20C,      32'h300,      1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h300,      32'h304,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h304,      32'h308,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,32'h18,  0,0,32'h0,   32'h308,      32'h18,       1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h18,       32'h1C,       1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h1C,       32'h20,       1,1,0));
        tbl.push_back(mk(1,0,32'h0,        0,32'h0,   1,1,32'h80,  32'h20,       32'h20,       0,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   1,1,32'h80,  32'h20,       32'h80,       1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   1,0,32'h999, 32'h80,       32'h84,       1,0,1));
        tbl.push_back(mk(0,1,32'h1000,     0,32'h0,   0,0,32'h0,   32'h84,       32'h1000,     1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h1000,     32'h1004,     1,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,32'h500, 0,0,32'h0,   32'h1004,     32'h500,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h500,      32'h504,      1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h504,      32'h508,      1,1,0));
        tbl.push_back(mk(0,1,32'h203,      0,32'h0,   0,0,32'h0,   32'h508,      32'h200,      1,0,1));
        tbl.push_back(mk(1,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h200,      32'h200,      0,1,0));
        tbl.push_back(mk(1,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h200,      32'h200,      0,1,0));
        tbl.push_back(mk(1,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h200,      32'h200,      0,0,1));
        tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,32'h0,   0,0,32'h0,   32'h200,      32'hFFFF_FFFC,1,0,1));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'hFFFF_FFFC,32'h0,        1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h0,        32'h4,        1,1,0));
        tbl.push_back(mk(0,0,32'h0,        0,32'h0,   0,0,32'h0,   32'h4,        32'h8,        1,0,1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].jp, tbl[i].jpc,
                  tbl[i].bv, tbl[i].bt, tbl[i].bpc);
            #1;
            chk($sformatf("vec%0d_pc", i),    pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_next", i),  next_pc, tbl[i].e_nxt);
            chk($sformatf("vec%0d_en", i),    {31'd0, pc_en}, {31'd0, tbl[i].e_en});
            chk($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].e_fl});
            chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_v});
            @(negedge clk);
        end

        // Reset asserted in the middle of a flush window.
        idle();
        ex_redirect_en = 1'b1; ex_redirect_pc = 32'h40;
        @(negedge clk);
        idle();
        #1;
        chk("midflush_pre_flush", {31'd0, flush}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midflush_rst_pc", pc, RV);
        chk("midflush_rst_flush", {31'd0, flush}, 32'd1);
        chk("midflush_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("midflush_rst_en", {31'd0, pc_en}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("after_rst_boot_pc", pc, RV);
        chk("after_rst_boot_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        #1;
        chk("after_rst_run_pc", pc, RV);
        chk("after_rst_run_flush", {31'd0, flush}, 32'd0);
        chk("after_rst_run_valid", {31'd0, if_valid}, 32'd1);
        @(negedge clk);

`ifdef FETCH_CTRL_PERF_EN
        chk("perf_redirect_zero", {16'd0, perf_redirect_cnt}, 32'd0);
        chk("perf_stall_zero", {16'd0, perf_stall_cnt}, 32'd0);
        ex_redirect_en = 1'b1; ex_redirect_pc = 32'h100;
        @(negedge clk);
        ex_redirect_pc = 32'h200;
        @(negedge clk);
        idle();
        #1;
        chk("perf_redirect_two", {16'd0, perf_redirect_cnt}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        stall_req = 1'b1;
        repeat (3) @(negedge clk);
        stall_req = 1'b0;
        #1;
        chk("perf_stall_three", {16'd0, perf_stall_cnt}, 32'd3);
        @(negedge clk);
`endif

        // Randomized phase against the reference model.
        rst = 1'b0;
        idle();
        #1;
        model_check("rnd_init");
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) != 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom(),
                  $urandom_range(0, 9) == 0, $urandom(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom());
            #1;
            model_check("rnd");
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the IF stage. Owns the architectural PC register and selects each cycle's next PC from four sources: EX-stage mispredict redirect, jump, BTB prediction, and sequential PC+4.
- Generates pc_en, a multi-cycle flush pulse that kills wrong-path instructions in IF/ID, and a valid qualifier for the fetched instruction.
- Sits between the hazard/branch-resolution logic and the instruction-memory address port; replaces the free-running PC-plus-mux arrangement.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush/bubble is held after a redirect or jump; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- stall_req  input  1  hazard unit requests PC hold.
- ex_redirect_en  input  1  EX resolved a mispredicted branch.
- ex_redirect_pc  input  32  corrected target from EX.
- jump_en  input  1  unconditional jump resolved.
- pc_jump_addr  input  32  jump target.
- btb_pc_valid  input  1  BTB hit for current pc.
- btb_pc_predictTaken  input  1  BTB predicts taken.
- btb_target_pc  input  32  BTB predicted target.
- pc  output  32  current fetch PC; drives inst_mem address.
- next_pc  output  32  combinational PC selected for the next edge.
- pc_en  output  1  PC register updates this cycle.
- flush  output  1  kill IF/ID contents (registered).
- if_valid  output  1  instruction at pc is on the correct path and may enter ID.

Behaviour:
- Reset (rst=0, async): pc=RESET_VECTOR, state=BOOT, flush=1, if_valid=0, flush counter=0. pc_en=0 while in reset.
- States: BOOT, RUN, STALL, FLUSH.
- BOOT: exactly one cycle after reset release. pc holds RESET_VECTOR, pc_en=0, flush=1, if_valid=0. Next state is RUN.
- next_pc selection, highest priority first:
  - ex_redirect_en: ex_redirect_pc.
  - jump_en: pc_jump_addr.
  - stall_req: pc (hold).
  - btb_pc_valid && btb_pc_predictTaken: btb_target_pc.
  - otherwise: pc+4.
- next_pc[1:0] is forced to 2'b00 for every source.
- pc+4 is a 32-bit add that wraps: 32'hFFFF_FFFC goes to 32'h0000_0000.
- pc_en=1 in RUN, STALL and FLUSH whenever next_pc != hold, i.e. a redirect/jump is present or stall_req=0. pc_en=0 in BOOT.
- RUN:
  - if_valid=1, flush=0.
  - redirect or jump: load target, load counter with FLUSH_CYCLES, go to FLUSH.
  - else stall_req: go to STALL.
- STALL:
  - pc held, if_valid=1, flush=0.
  - redirect/jump: go to FLUSH (as from RUN).
  - stall_req=0: go to RUN.
- FLUSH:
  - flush=1, if_valid=0.
  - Counter decrements every cycle, including stalled cycles.
  - pc advances per the priority rules; stall_req holds pc.
  - On reaching 0, go to RUN, or to STALL if stall_req=1 that cycle.
  - A redirect or jump in FLUSH reloads the counter with FLUSH_CYCLES and loads the new target.
- Simultaneous ex_redirect_en and jump_en: the redirect wins; jump_en is ignored.
- Latency: a redirect seen at edge N gives pc=target after edge N, with flush high for FLUSH_CYCLES cycles starting that same cycle.
- Reset asserted mid-FLUSH or mid-STALL: immediate return to the reset values; the counter clears.
- BTB prediction is ignored when stall_req=1 and in BOOT.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, adds outputs perf_redirect_cnt[15:0] and perf_stall_cnt[15:0].
  - perf_redirect_cnt counts accepted redirect/jump events.
  - perf_stall_cnt counts cycles with stall_req=1 in RUN/STALL.
  - Both saturate at 16'hFFFF, reset to 0 asynchronously with rst, and do not count in BOOT.
- When undefined, these ports and counters do not exist and functional behaviour is identical.

Test Plan:
- Reset release, no other inputs: cycle 0 in BOOT with pc=0, flush=1. Then pc=0,4,8,… each cycle with pc_en=1, if_valid=1.
- At pc=0x10, pulse ex_redirect_en with ex_redirect_pc=0x200: pc=0x200 next cycle, flush=1 for exactly 2 cycles, if_valid=0 for those cycles, then 0x204…
- Same cycle ex_redirect_en (0x300) and jump_en (0x400): pc=0x300; jump ignored.
- BTB hit with predictTaken at pc=0x20, target 0x80: pc=0x80 next cycle with no flush. Repeat with stall_req=1: pc holds at 0x20.
- Redirect, then a second jump to 0x500 during the 2nd flush cycle: the counter reloads and flush stays high 2 more cycles from 0x500. Then force pc=0xFFFF_FFFC sequentially: wraps to 0x0. Misaligned target 0x203 loads 0x200.
- Assert rst low mid-FLUSH: pc=RESET_VECTOR immediately, flush=1, if_valid=0. With FETCH_CTRL_PERF_EN defined, counters read 0 after reset and 2 after two redirects.
